shift_operand_fetch: RTL and testbench

- Decode/operand-fetch stage directly upstream of the ARM barrel shifter (shifter_rotater).
- Accepts one data-processing instruction at a time over a valid/ready handshake and decodes its operand-2 field.
- Fetches Rm and, when needed, Rs through a single synchronous register-file read port, with special handling for R15.
- Presents a registered, shifter-ready operand bundle (data, shift control, amounts, carry-in) with a one-cycle shifter enable pulse on handoff.

---
 rtl/shift_operand_fetch_if.sv | 34 +++
 rtl/shift_operand_fetch.sv | 180 ++++++++++++++++++
 tb/tb_shift_operand_fetch.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_operand_fetch_if.sv
// Handshake, register-file and shifter-bundle signals of the shift operand fetch stage.
// The slave side is the stage itself; the master side is its surroundings.
interface shift_operand_fetch_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_carry;
    logic        rf_re;
    logic [3:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic [31:0] shift_amt_reg;
    logic [4:0]  shift_amt_imm;
    logic [2:0]  shift_control;
    logic        carry_flag;
    logic        shift_enable;
    logic [31:0] out_instr;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, in_carry, rf_rdata, out_ready,
        output in_ready, rf_re, rf_addr, out_valid, in_data, shift_amt_reg,
               shift_amt_imm, shift_control, carry_flag, shift_enable, out_instr
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, in_carry, rf_rdata, out_ready,
        input  in_ready, rf_re, rf_addr, out_valid, in_data, shift_amt_reg,
               shift_amt_imm, shift_control, carry_flag, shift_enable, out_instr
    );
endinterface

// File: rtl/shift_operand_fetch.sv
// Decode/operand-fetch stage feeding the barrel shifter: decodes operand 2, reads Rm/Rs
// through one synchronous register-file port and presents a registered shifter bundle.
module shift_operand_fetch #(
    parameter logic [31:0] PC_OFF_IMM = 32'd8,
    parameter logic [31:0] PC_OFF_REG = 32'd12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    shift_operand_fetch_if.slave  bus
);
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 4;
    localparam int unsigned IMW = 5;
    localparam int unsigned CW  = 3;
    localparam logic [AW-1:0] R15 = 4'hF;

    typedef enum logic [1:0] {IDLE, RD_RM, RD_RS, OUT} state_t;

    state_t          state;
    state_t          state_next;

    logic [DW-1:0]   instr_q;
    logic [DW-1:0]   pc_q;
    logic [DW-1:0]   in_data_q;
    logic [DW-1:0]   amt_reg_q;
    logic [IMW-1:0]  amt_imm_q;
    logic [CW-1:0]   ctrl_q;
    logic            carry_q;
    logic            out_valid_q;

    logic            in_ready_c;
    logic            accept_c;
    logic            rf_re_c;
    logic [AW-1:0]   rf_addr_c;
    logic [DW-1:0]   pc_imm_c;

    logic [DW-1:0]   dec_data;
    logic [DW-1:0]   dec_amt_reg;
    logic [IMW-1:0]  dec_amt_imm;
    logic [CW-1:0]   dec_ctrl;

    // Reset and flush both block a new accept in the cycle they are asserted.
    assign in_ready_c = (state == IDLE) && reset_n && !bus.flush;
    assign accept_c   = bus.in_valid && in_ready_c;
    assign pc_imm_c   = pc_q + PC_OFF_IMM;

    // Operand-2 decode of the instruction being offered; only used on accept.
    always_comb begin
        dec_data    = '0;
        dec_amt_reg = '0;
        dec_amt_imm = '0;
        dec_ctrl    = '0;
        if (bus.in_instr[25]) begin
            dec_data = {24'b0, bus.in_instr[7:0]};
            if (bus.in_instr[11:8] != 4'd0) begin
                dec_ctrl    = 3'b110;
                dec_amt_imm = {bus.in_instr[11:8], 1'b0};
            end
        end else if (bus.in_instr[4]) begin
            dec_ctrl = {bus.in_instr[6:5], 1'b1};
        end else begin
            dec_ctrl    = {bus.in_instr[6:5], 1'b0};
            dec_amt_imm = bus.in_instr[11:7];
            // LSR #0 / ASR #0 encode a shift by 32, expressed through the register form.
            if (bus.in_instr[11:7] == 5'd0) begin
                if (bus.in_instr[6:5] == 2'b01) begin
                    dec_ctrl    = 3'b011;
                    dec_amt_reg = DW'(32);
                end else if (bus.in_instr[6:5] == 2'b10) begin
                    dec_ctrl    = 3'b101;
                    dec_amt_reg = DW'(32);
                end
            end
        end
    end

    // Next state and register-file read strobe.
    always_comb begin
        state_next = state;
        rf_re_c    = 1'b0;
        rf_addr_c  = '0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (bus.in_instr[25]) begin
                        state_next = OUT;
                    end else begin
                        state_next = RD_RM;
                        if (bus.in_instr[3:0] != R15) begin
                            rf_re_c   = 1'b1;
                            rf_addr_c = bus.in_instr[3:0];
                        end
                    end
                end
            end
            RD_RM: begin
                if (instr_q[4]) begin
                    state_next = RD_RS;
                    if (instr_q[11:8] != R15) begin
                        rf_re_c   = 1'b1;
                        rf_addr_c = instr_q[11:8];
                    end
                end else begin
                    state_next = OUT;
                end
            end
            RD_RS: state_next = OUT;
            OUT: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!reset_n || bus.flush) begin
            state_next = IDLE;
            rf_re_c    = 1'b0;
            rf_addr_c  = '0;
        end
    end

    // State register and operand bundle; flush drops the instruction but keeps data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            pc_q        <= '0;
            in_data_q   <= '0;
            amt_reg_q   <= '0;
            amt_imm_q   <= '0;
            ctrl_q      <= '0;
            carry_q     <= 1'b0;
        end else begin
            state       <= state_next;
            out_valid_q <= (state_next == OUT);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        instr_q   <= bus.in_instr;
                        pc_q      <= bus.in_pc;
                        carry_q   <= bus.in_carry;
                        in_data_q <= dec_data;
                        amt_reg_q <= dec_amt_reg;
                        amt_imm_q <= dec_amt_imm;
                        ctrl_q    <= dec_ctrl;
                    end
                end
                RD_RM: begin
                    if (instr_q[3:0] == R15) begin
                        in_data_q <= instr_q[4] ? (pc_q + PC_OFF_REG) : pc_imm_c;
                    end else begin
                        in_data_q <= bus.rf_rdata;
                    end
                end
                RD_RS: begin
                    // Only the bottom byte of Rs is a shift amount.
                    if (instr_q[11:8] == R15) begin
                        amt_reg_q <= {24'b0, pc_imm_c[7:0]};
                    end else begin
                        amt_reg_q <= {24'b0, bus.rf_rdata[7:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = in_ready_c;
    assign bus.rf_re         = rf_re_c;
    assign bus.rf_addr       = rf_addr_c;
    assign bus.out_valid     = out_valid_q;
    assign bus.in_data       = in_data_q;
    assign bus.shift_amt_reg = amt_reg_q;
    assign bus.shift_amt_imm = amt_imm_q;
    assign bus.shift_control = ctrl_q;
    assign bus.carry_flag    = carry_q;
    assign bus.out_instr     = instr_q;
    assign bus.shift_enable  = out_valid_q && bus.out_ready && !bus.flush && reset_n;
endmodule

// File: tb/tb_shift_operand_fetch.sv
// Scoreboard bench for shift_operand_fetch: stimulus pushes modelled bundles, a negedge
// monitor pops and compares them, plus directed reset/flush/backpressure scenarios.
module tb_shift_operand_fetch;
    logic clk = 1'b0;
    logic reset_n;

    shift_operand_fetch_if bus ();

    shift_operand_fetch dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] amt_reg;
        logic [4:0]  amt_imm;
        logic [2:0]  ctrl;
        logic        carry;
        logic [31:0] instr;
        int          lat;
        int          nrd;
        logic [3:0]  rd0;
        logic [3:0]  rd1;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [3:0]  rd_q[$];
    logic [31:0] regs [16];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          holding  = 0;
    bit          or_mode  = 1;
    bit          or_val   = 0;
    logic [127:0] snap;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file with one-cycle read latency; unread cycles return noise.
    always @(posedge clk) bus.rf_rdata <= bus.rf_re ? regs[bus.rf_addr] : $urandom();

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = or_mode ? or_val : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [127:0] bundle();
        return {23'd0, bus.out_valid, bus.in_data, bus.shift_amt_reg, bus.shift_amt_imm,
                bus.shift_control, bus.carry_flag, bus.out_instr};
    endfunction

    // ARM operand-2 semantics, computed directly from the instruction fields.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input logic c);
        exp_t e;
        int unsigned typ;
        int unsigned amt;
        logic [3:0] rm;
        logic [3:0] rs;
        e = '{default: 0};
        e.instr = ins;
        e.carry = c;
        rm = ins[3:0];
        rs = ins[11:8];
        if (ins[25]) begin
            e.lat  = 1;
            e.data = 32'(ins[7:0]);
            if (rs != 0) begin
                e.ctrl    = 3'd6;
                e.amt_imm = 5'(2 * rs);
            end
        end else begin
            typ = ins[6:5];
            if (rm == 15) begin
                e.data = pc + (ins[4] ? 32'd12 : 32'd8);
            end else begin
                e.data = regs[rm];
                e.rd0  = rm;
                e.nrd  = 1;
            end
            if (ins[4]) begin
                e.lat  = 3;
                e.ctrl = 3'(2 * typ + 1);
                if (rs == 15) begin
                    e.amt_reg = (pc + 32'd8) % 256;
                end else begin
                    e.amt_reg = regs[rs] % 256;
                    if (e.nrd == 0) e.rd0 = rs;
                    else e.rd1 = rs;
                    e.nrd++;
                end
            end else begin
                e.lat = 2;
                amt = ins[11:7];
                if (amt == 0 && typ == 1) begin
                    e.ctrl    = 3'd3;
                    e.amt_reg = 32;
                end else if (amt == 0 && typ == 2) begin
                    e.ctrl    = 3'd5;
                    e.amt_reg = 32;
                end else begin
                    e.ctrl    = 3'(2 * typ);
                    e.amt_imm = 5'(amt);
                end
            end
        end
        return e;
    endfunction

    // Monitor: read log, handoff pulse, bundle compare and hold stability.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] a0;
        logic [3:0] a1;
        if (!reset_n) begin
            holding = 0;
            rd_q.delete();
        end else begin
            if (bus.rf_re) rd_q.push_back(bus.rf_addr);
            if (bus.out_valid || bus.shift_enable)
                chk("shift_enable", bus.shift_enable, bus.out_valid && bus.out_ready && !bus.flush);
            if (bus.out_valid) chk("in_ready_busy", bus.in_ready, 0);
            if (bus.out_valid && !holding) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    chk("in_data", bus.in_data, e.data);
                    chk("shift_amt_reg", bus.shift_amt_reg, e.amt_reg);
                    chk("shift_amt_imm", bus.shift_amt_imm, e.amt_imm);
                    chk("shift_control", bus.shift_control, e.ctrl);
                    chk("carry_flag", bus.carry_flag, e.carry);
                    chk("out_instr", bus.out_instr, e.instr);
                    chk("latency", cyc - e.acc, e.lat);
                    a0 = (rd_q.size() > 0) ? rd_q[0] : 4'd0;
                    a1 = (rd_q.size() > 1) ? rd_q[1] : 4'd0;
                    chk("rf_reads", {32'(rd_q.size()), a0, a1}, {32'(e.nrd), e.rd0, e.rd1});
                end
                rd_q.delete();
                snap = bundle();
                holding = 1;
            end else if (bus.out_valid && holding) begin
                chk("hold_stable", bundle(), snap);
            end
            if (holding && (bus.flush || (bus.out_valid && bus.out_ready))) holding = 0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) fail_now("idle_timeout");
    endtask

    task automatic rand_regs();
        for (int i = 0; i < 16; i++) regs[i] = $urandom();
    endtask

    // Offer one instruction; returns #1 after the accept edge (or one cycle later with garbage).
    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic c, input bit garbage);
        exp_t e;
        int n = 0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_pc    = pc;
        bus.in_carry = c;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            fail_now("accept_timeout");
            bus.in_valid = 1'b0;
            return;
        end
        e = model(ins, pc, c);
        e.acc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (garbage) begin
            bus.in_instr = $urandom();
            bus.in_pc    = $urandom();
            bus.in_carry = 1'($urandom());
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] x;
        x = $urandom();
        if ($urandom_range(0, 3) == 0) x[3:0] = 4'hF;
        if ($urandom_range(0, 3) == 0) x[11:8] = 4'hF;
        if ($urandom_range(0, 2) == 0) x[11:7] = 5'd0;
        return x;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n      = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.in_pc    = '0;
        bus.in_carry = 1'b0;
        rand_regs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_bundle", bundle(), 128'd0);
        chk("init_rf_re", bus.rf_re, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("init_in_ready", bus.in_ready, 1);

        // Rotated immediate 0xFF ror 8 with carry set.
        or_mode = 1;
        or_val  = 1;
        send(32'hE3A004FF, 32'h0, 1'b1, 1'b0);

        // LSR #0 becomes LSR by 32.
        wait_idle();
        regs[1] = 32'h8000_0000;
        send(32'hE1A00021, 32'h40, 1'b0, 1'b0);

        // Register shift with Rm = R15, amount from R3.
        wait_idle();
        regs[3] = 32'hFFFF_FF04;
        send(32'hE1A0031F, 32'h100, 1'b0, 1'b0);

        // Backpressure: five stalled cycles then a single handoff pulse.
        wait_idle();
        or_val = 0;
        send(32'hE3A00C7F, 32'h0, 1'b0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_stall_se", bus.shift_enable, 0);
        end
        or_val = 1;
        @(negedge clk);
        chk("bp_pulse", bus.shift_enable, 1);
        @(negedge clk);
        chk("bp_release_ready", bus.in_ready, 1);
        chk("bp_release_se", bus.shift_enable, 0);

        // Flush while Rm is being read: no Rs read, no output.
        wait_idle();
        rand_regs();
        send(32'hE1A00352, 32'h0, 1'b0, 1'b0);
        bus.flush = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_rm_ready", bus.in_ready, 1);
        chk("flush_rm_reads", {32'(rd_q.size()), (rd_q.size() > 0) ? rd_q[0] : 4'd0}, {32'd1, 4'd2});
        repeat (3) begin
            @(negedge clk);
            chk("flush_rm_no_out", bus.out_valid, 0);
        end
        rd_q.delete();

        // Flush in the same cycle as out_ready: no handoff pulse.
        or_val = 0;
        send(32'hE3A00012, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        or_val = 1;
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_out_se", bus.shift_enable, 0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_out_ready", bus.in_ready, 1);
        exp_q.delete();

        // Reset held two cycles while in RD_RS.
        or_val = 0;
        send(32'hE1A00312, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_bundle", bundle(), 128'd0);
        chk("rst_rf_re", bus.rf_re, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_rf_re_after", bus.rf_re, 0);
        chk("rst_out_valid", bus.out_valid, 0);

        // Randomized traffic with random backpressure and noise on in_valid while busy.
        or_mode = 0;
        for (int i = 0; i < 60; i++) begin
            wait_idle();
            rand_regs();
            send(gen_instr(), $urandom() & 32'hFFFF_FFFC, 1'($urandom()), 1'($urandom()));
        end

        n = 0;
        while ((exp_q.size() != 0 || holding) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || holding) fail_now("drain_timeout");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
